fdma_frame_wctrl: RTL

- Upstream command/data stage for the FDMA write channel.
- Consumes a video line stream from a single-clock first-word-fall-through (FWFT) line FIFO, one pixel word per entry.
- Issues one FDMA write request per video line (waddr/wareq/wsize), streams FIFO words into the FDMA data port, and rotates through BUF_NUM frame buffers in DDR.
- Reports the last completed buffer index to the downstream read side.

---
 rtl/fdma_frame_wctrl.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/fdma_frame_wctrl.sv
// FDMA write-side line controller: one write request per video line from an FWFT
// line FIFO, rotating through BUF_NUM frame buffers and publishing the last finished one.
module fdma_frame_wctrl #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned H_WORDS    = 240,
  parameter int unsigned V_LINES    = 720,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(32'h1000_0000),
  parameter logic [ADDR_WIDTH-1:0] BUF_STRIDE = ADDR_WIDTH'(32'h0080_0000),
  parameter int unsigned BUF_NUM    = 3,
  parameter int unsigned CNT_WIDTH  = 12
) (
  input  logic                  M_AXI_ACLK,
  input  logic                  M_AXI_ARESET,
  input  logic                  frame_sync,
  input  logic [CNT_WIDTH-1:0]  fifo_rd_cnt,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_rd_en,
  output logic [ADDR_WIDTH-1:0] fdma_waddr,
  output logic                  fdma_wareq,
  output logic [15:0]           fdma_wsize,
  input  logic                  fdma_wbusy,
  output logic [DATA_WIDTH-1:0] fdma_wdata,
  input  logic                  fdma_wvalid,
  output logic                  fdma_wready,
  output logic [1:0]            wbuf_idx,
  output logic                  frame_done,
  output logic                  xfer_err
);

  localparam int unsigned AXI_BYTES = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] LINE_STEP = ADDR_WIDTH'(H_WORDS * AXI_BYTES);
  localparam logic [15:0] H_WORDS_16 = 16'(H_WORDS);
  localparam logic [11:0] LAST_LINE  = 12'(V_LINES - 1);
  localparam logic [1:0]  LAST_BUF   = 2'(BUF_NUM - 1);

  typedef enum logic [2:0] {
    WAIT_FS   = 3'd0,
    WAIT_DATA = 3'd1,
    REQ       = 3'd2,
    XFER      = 3'd3,
    LINE_DONE = 3'd4
  } state_t;

  state_t                  state_r, state_s;
  logic [11:0]             line_r, line_s;
  logic [1:0]              buf_r, buf_s;
  logic [1:0]              next_buf_s;
  logic [ADDR_WIDTH-1:0]   waddr_r, waddr_s;
  logic [15:0]             wcnt_r, wcnt_s;
  logic                    pend_r, pend_s;
  logic [1:0]              wbuf_r, wbuf_s;
  logic                    err_r, err_s;
  logic                    done_s;
  logic                    wareq_r, wready_r, done_r;
  logic                    data_ok_s;
  logic                    resync_s;

  function automatic logic [ADDR_WIDTH-1:0] buf_base(input logic [1:0] idx);
    return BASE_ADDR + ADDR_WIDTH'(idx) * BUF_STRIDE;
  endfunction

  assign data_ok_s   = 32'(fifo_rd_cnt) >= 32'(H_WORDS);
  assign fdma_wsize  = H_WORDS_16;
  assign fdma_wdata  = fifo_rdata;
  assign fifo_rd_en  = fdma_wvalid & wready_r;
  assign fdma_wareq  = wareq_r;
  assign fdma_wready = wready_r;
  assign fdma_waddr  = waddr_r;
  assign wbuf_idx    = wbuf_r;
  assign frame_done  = done_r;
  assign xfer_err    = err_r;

  // next-state and datapath update for the line/frame sequencer
  always_comb begin
    state_s    = state_r;
    line_s     = line_r;
    buf_s      = buf_r;
    waddr_s    = waddr_r;
    wcnt_s     = wcnt_r;
    pend_s     = pend_r;
    wbuf_s     = wbuf_r;
    err_s      = err_r;
    done_s     = 1'b0;
    resync_s   = pend_r | frame_sync;
    next_buf_s = (buf_r == LAST_BUF) ? 2'd0 : buf_r + 2'd1;
    case (state_r)
      WAIT_FS: begin
        if (frame_sync) begin
          state_s = WAIT_DATA;
          line_s  = 12'd0;
          waddr_s = buf_base(buf_r);
        end else begin
          state_s = WAIT_FS;
        end
      end
      WAIT_DATA: begin
        // a sync here abandons the partial frame and restarts line 0 of the same buffer
        if (frame_sync) begin
          line_s  = 12'd0;
          waddr_s = buf_base(buf_r);
        end else if (data_ok_s && !fdma_wbusy) begin
          state_s = REQ;
        end else begin
          state_s = WAIT_DATA;
        end
      end
      REQ: begin
        pend_s = resync_s;
        if (fdma_wbusy) begin
          state_s = XFER;
        end else begin
          state_s = REQ;
        end
      end
      XFER: begin
        pend_s = resync_s;
        if (fdma_wvalid) begin
          wcnt_s = wcnt_r + 16'd1;
        end else begin
          wcnt_s = wcnt_r;
        end
        if (!fdma_wbusy) begin
          state_s = LINE_DONE;
          done_s  = (line_r == LAST_LINE);
        end else begin
          state_s = XFER;
        end
      end
      LINE_DONE: begin
        err_s  = err_r | (wcnt_r != H_WORDS_16);
        wcnt_s = 16'd0;
        pend_s = 1'b0;
        if (line_r == LAST_LINE) begin
          // completion wins over a pending sync; the sync then starts the next frame
          wbuf_s = buf_r;
          buf_s  = next_buf_s;
          line_s = 12'd0;
          if (resync_s) begin
            state_s = WAIT_DATA;
            waddr_s = buf_base(next_buf_s);
          end else begin
            state_s = WAIT_FS;
          end
        end else if (resync_s) begin
          state_s = WAIT_DATA;
          line_s  = 12'd0;
          waddr_s = buf_base(buf_r);
        end else begin
          state_s = WAIT_DATA;
          line_s  = line_r + 12'd1;
          waddr_s = waddr_r + LINE_STEP;
        end
      end
      default: begin
        state_s = WAIT_FS;
      end
    endcase
  end

  // state, datapath and registered output flags
  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      state_r  <= WAIT_FS;
      line_r   <= 12'd0;
      buf_r    <= 2'd0;
      waddr_r  <= BASE_ADDR;
      wcnt_r   <= 16'd0;
      pend_r   <= 1'b0;
      wbuf_r   <= LAST_BUF;
      err_r    <= 1'b0;
      wareq_r  <= 1'b0;
      wready_r <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      line_r   <= line_s;
      buf_r    <= buf_s;
      waddr_r  <= waddr_s;
      wcnt_r   <= wcnt_s;
      pend_r   <= pend_s;
      wbuf_r   <= wbuf_s;
      err_r    <= err_s;
      wareq_r  <= (state_s == REQ);
      wready_r <= (state_s == XFER);
      done_r   <= done_s;
    end
  end

endmodule
